mem_access_unit: RTL and testbench

Load/store unit between the execute stage and the word-addressed data memory stage. Takes byte-addressed load/store requests of byte, halfword or word size. Drives the memory's word address, write enable and write data. Returns sign- or zero-extended load results to writeback through a registered output. Sub-word stores are done as a two-cycle read-modify-write, because the memory only writes whole words; the unit stalls upstream for that one extra cycle.

---
 rtl/mem_access_unit_if.sv | 42 ++++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request, data-memory and writeback bundle for mem_access_unit.
// master = execute/memory side, slave = the load/store unit.
interface mem_access_unit_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    logic              wb_valid;
    logic [31:0]       wb_data;
    logic [4:0]        wb_rd;
    logic              exc_misalign;

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata, req_rd,
        input  req_ready,
        input  ram_addr, ram_we, ram_din,
        output ram_dout,
        input  wb_valid, wb_data, wb_rd, exc_misalign
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata, req_rd,
        output req_ready,
        output ram_addr, ram_we, ram_din,
        input  ram_dout,
        output wb_valid, wb_data, wb_rd, exc_misalign
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit with read-modify-write for sub-word stores.
// MEM_ACCESS_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning.
module mem_access_unit #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             reset_,
    mem_access_unit_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] MERGE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] cap_word_q, cap_word_d;
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic [1:0]        cap_lane_q, cap_lane_d;
    logic              cap_half_q, cap_half_d;
    logic [15:0]       cap_wdata_q, cap_wdata_d;

    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              exc_q, exc_d;

    logic is_byte, is_half, is_word, is_rsvd;
    logic mis;
    logic [1:0] lane;
    logic accept, do_load, st_word, st_sub;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] merged;
    logic unused_addr;

    assign is_byte = bus.req_size == 2'b00;
    assign is_half = bus.req_size == 2'b01;
    assign is_word = bus.req_size == 2'b10;
    assign is_rsvd = bus.req_size == 2'b11;

    assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign mis  = (is_half & bus.req_addr[0])
                | (is_word & (|bus.req_addr[1:0]));
    assign lane = bus.req_addr[1:0];
`else
    // Offending low bits are dropped so the access lands on its natural lane.
    assign mis  = 1'b0;
    assign lane = is_half ? {bus.req_addr[1], 1'b0} :
                  is_word ? 2'b00 : bus.req_addr[1:0];
`endif

    assign accept  = (state_q == IDLE) & bus.req_valid;
    assign do_load = accept & ~bus.req_we & ~is_rsvd & ~mis;
    assign st_word = accept & bus.req_we & is_word & ~mis;
    assign st_sub  = accept & bus.req_we & (is_byte | is_half) & ~mis;

    always_comb begin
        byte_v = 8'h00;
        unique case (lane)
            2'd0: byte_v = bus.ram_dout[7:0];
            2'd1: byte_v = bus.ram_dout[15:8];
            2'd2: byte_v = bus.ram_dout[23:16];
            2'd3: byte_v = bus.ram_dout[31:24];
        endcase
        half_v = lane[1] ? bus.ram_dout[31:16] : bus.ram_dout[15:0];
    end

    always_comb begin
        ld_data = bus.ram_dout;
        unique case (1'b1)
            is_byte: ld_data = {{24{~bus.req_unsigned & byte_v[7]}}, byte_v};
            is_half: ld_data = {{16{~bus.req_unsigned & half_v[15]}}, half_v};
            default: ld_data = bus.ram_dout;
        endcase
    end

    always_comb begin
        merged = cap_word_q;
        if (cap_half_q)
            merged[{cap_lane_q[1], 4'b0000} +: 16] = cap_wdata_q;
        else
            merged[{cap_lane_q, 3'b000} +: 8] = cap_wdata_q[7:0];
    end

    always_comb begin
        state_d     = IDLE;
        cap_word_d  = cap_word_q;
        cap_addr_d  = cap_addr_q;
        cap_lane_d  = cap_lane_q;
        cap_half_d  = cap_half_q;
        cap_wdata_d = cap_wdata_q;
        if (st_sub) begin
            state_d     = MERGE;
            cap_word_d  = bus.ram_dout;
            cap_addr_d  = bus.req_addr[ADDR_W+1:2];
            cap_lane_d  = lane;
            cap_half_d  = is_half;
            cap_wdata_d = bus.req_wdata[15:0];
        end
    end

    always_comb begin
        wb_valid_d = do_load;
        wb_data_d  = do_load ? ld_data : wb_data_q;
        wb_rd_d    = do_load ? bus.req_rd : wb_rd_q;
        exc_d      = accept & mis;
    end

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            state_q     <= IDLE;
            cap_word_q  <= '0;
            cap_addr_q  <= '0;
            cap_lane_q  <= '0;
            cap_half_q  <= 1'b0;
            cap_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_word_q  <= cap_word_d;
            cap_addr_q  <= cap_addr_d;
            cap_lane_q  <= cap_lane_d;
            cap_half_q  <= cap_half_d;
            cap_wdata_q <= cap_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            exc_q       <= exc_d;
        end
    end

    assign bus.req_ready = state_q == IDLE;
    assign bus.ram_addr  = (state_q == MERGE) ? cap_addr_q
                                              : bus.req_addr[ADDR_W+1:2];
    // Reset gates the write enable directly so a pending merge is dropped at once.
    assign bus.ram_we    = ~reset_ & ((state_q == MERGE) | st_word);
    assign bus.ram_din   = (state_q == MERGE) ? merged : bus.req_wdata;

    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.exc_misalign = exc_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 1024-word memory model.
module tb_mem_access_unit;
    logic clk;
    logic reset_;
    int   n_chk;
    int   n_fail;

    logic [31:0] mem [1024];

    mem_access_unit_if #(.ADDR_W(10)) bus ();

    mem_access_unit #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ram_dout = mem[bus.ram_addr];
    always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                         input logic un, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        @(negedge clk);
        bus.req_valid    = v;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = un;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset_ = 1'b1;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_wdata    = 32'h1;
        bus.req_rd       = 5'd0;
        step();
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_we", {31'd0, bus.ram_we}, 32'd0);
        check("rst_wbv", {31'd0, bus.wb_valid}, 32'd0);
        check("rst_wbd", bus.wb_data, 32'd0);
        check("rst_wbrd", {27'd0, bus.wb_rd}, 32'd0);
        check("rst_exc", {31'd0, bus.exc_misalign}, 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset_ = 1'b0;

        // word store then word load
        drive(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
        #1;
        check("sw_we", {31'd0, bus.ram_we}, 32'd1);
        check("sw_addr", {22'd0, bus.ram_addr}, 32'd4);
        check("sw_din", bus.ram_din, 32'hDEADBEEF);
        step();
        check("sw_mem", mem[4], 32'hDEADBEEF);
        drive(1, 0, 2'b10, 0, 32'h10, 0, 5'd7);
        #1;
        check("lw_nowe", {31'd0, bus.ram_we}, 32'd0);
        step();
        check("lw_v", {31'd0, bus.wb_valid}, 32'd1);
        check("lw_d", bus.wb_data, 32'hDEADBEEF);
        check("lw_rd", {27'd0, bus.wb_rd}, 32'd7);

        // byte store over 0x11223344 at word 8
        drive(1, 1, 2'b10, 0, 32'h20, 32'h11223344, 0);
        step();
        check("sw2_v", {31'd0, bus.wb_valid}, 32'd0);
        drive(1, 1, 2'b00, 0, 32'h23, 32'hFFFFFFAA, 0);
        #1;
        check("sb_acc_we", {31'd0, bus.ram_we}, 32'd0);
        check("sb_acc_rdy", {31'd0, bus.req_ready}, 32'd1);
        step();
        check("sb_m_rdy", {31'd0, bus.req_ready}, 32'd0);
        check("sb_m_we", {31'd0, bus.ram_we}, 32'd1);
        check("sb_m_addr", {22'd0, bus.ram_addr}, 32'd8);
        check("sb_m_din", bus.ram_din, 32'hAA223344);
        drive(1, 0, 2'b00, 0, 32'h23, 0, 5'd1);
        step();
        check("sb_mem", mem[8], 32'hAA223344);
        check("sb_rdy2", {31'd0, bus.req_ready}, 32'd1);
        check("held_v", {31'd0, bus.wb_valid}, 32'd0);

        // back-to-back loads, first one already presented
        step();
        check("b1_v", {31'd0, bus.wb_valid}, 32'd1);
        check("b1_d", bus.wb_data, 32'hFFFFFFAA);
        check("b1_rd", {27'd0, bus.wb_rd}, 32'd1);
        drive(1, 0, 2'b00, 1, 32'h23, 0, 5'd2);
        step();
        check("b2_v", {31'd0, bus.wb_valid}, 32'd1);
        check("b2_d", bus.wb_data, 32'h000000AA);
        check("b2_rd", {27'd0, bus.wb_rd}, 32'd2);
        drive(1, 0, 2'b01, 1, 32'h22, 0, 5'd3);
        step();
        check("b3_v", {31'd0, bus.wb_valid}, 32'd1);
        check("b3_d", bus.wb_data, 32'h0000AA22);
        check("b3_rd", {27'd0, bus.wb_rd}, 32'd3);
        drive(1, 0, 2'b01, 0, 32'h22, 0, 5'd4);
        step();
        check("lh_s", bus.wb_data, 32'hFFFFAA22);
        drive(1, 0, 2'b00, 0, 32'h20, 0, 5'd6);
        step();
        check("lb0_s", bus.wb_data, 32'h00000044);
        drive(1, 1, 2'b11, 0, 32'h20, 32'h0, 5'd9);
        #1;
        check("rsv_we", {31'd0, bus.ram_we}, 32'd0);
        step();
        check("rsv_v", {31'd0, bus.wb_valid}, 32'd0);
        check("rsv_rdy", {31'd0, bus.req_ready}, 32'd1);
        check("rsv_mem", mem[8], 32'hAA223344);

        // misaligned word load at 0x11
        drive(1, 0, 2'b10, 0, 32'h11, 0, 5'd5);
        #1;
        check("mis_we", {31'd0, bus.ram_we}, 32'd0);
        step();
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        check("mis_exc", {31'd0, bus.exc_misalign}, 32'd1);
        check("mis_v", {31'd0, bus.wb_valid}, 32'd0);
`else
        check("mis_exc", {31'd0, bus.exc_misalign}, 32'd0);
        check("mis_v", {31'd0, bus.wb_valid}, 32'd1);
        check("mis_d", bus.wb_data, 32'hDEADBEEF);
`endif
        drive(0, 0, 2'b00, 0, 0, 0, 0);
        step();
        check("idle_exc", {31'd0, bus.exc_misalign}, 32'd0);
        check("idle_v", {31'd0, bus.wb_valid}, 32'd0);

        // reset during MERGE of a half store
        drive(1, 1, 2'b01, 0, 32'h22, 32'h5555, 0);
        step();
        check("rm_we", {31'd0, bus.ram_we}, 32'd1);
        bus.req_valid = 1'b0;
        reset_ = 1'b1;
        #1;
        check("rm_we_drop", {31'd0, bus.ram_we}, 32'd0);
        check("rm_rdy", {31'd0, bus.req_ready}, 32'd1);
        step();
        check("rm_mem", mem[8], 32'hAA223344);
        @(negedge clk);
        reset_ = 1'b0;
        #1;
        check("rr_rdy", {31'd0, bus.req_ready}, 32'd1);
        check("rr_v", {31'd0, bus.wb_valid}, 32'd0);
        check("rr_d", bus.wb_data, 32'd0);
        check("rr_rd", {27'd0, bus.wb_rd}, 32'd0);
        check("rr_exc", {31'd0, bus.exc_misalign}, 32'd0);

        // half store completes normally, then immediate load accepted
        drive(1, 1, 2'b01, 0, 32'h22, 32'h1234BEEF, 0);
        step();
        check("sh_m_din", bus.ram_din, 32'hBEEF3344);
        drive(1, 0, 2'b10, 0, 32'h20, 0, 5'd8);
        step();
        check("sh_mem", mem[8], 32'hBEEF3344);
        step();
        check("sh_ld", bus.wb_data, 32'hBEEF3344);
        check("sh_ld_rd", {27'd0, bus.wb_rd}, 32'd8);
        bus.req_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
